axi_imem_rd_slave: RTL

AXI4 read-only responder that serves instruction fetch bursts from an on-chip 64-bit instruction memory. It sits at the memory end of the fetch unit's AR/R channels and answers the WRAP bursts issued by the fetch-side cache refill logic. It also accepts INCR and FIXED bursts for loaders and debug. One transaction is outstanding at a time, and the R channel streams one beat per cycle under full `rready`.

---
 rtl/axi_imem_rd_slave_if.sv | 35 +++
 rtl/axi_imem_rd_slave.sv | 120 ++++++++++++
 2 files changed

// File: rtl/axi_imem_rd_slave_if.sv
// AR/R channel bundle between the fetch-side master and the instruction memory responder.
interface axi_imem_rd_slave_if #(
    parameter int AxiIdW = 4
);
    logic [AxiIdW-1:0] axi_arid;
    logic [31:0]       axi_araddr;
    logic [7:0]        axi_arlen;
    logic [2:0]        axi_arsize;
    logic [1:0]        axi_arburst;
    logic              axi_arvalid;
    logic              axi_arready;
    logic              axi_arlock;
    logic [3:0]        axi_arcache;
    logic [2:0]        axi_arprot;
    logic [3:0]        axi_arqos;
    logic [3:0]        axi_arregion;
    logic [AxiIdW-1:0] axi_rid;
    logic [63:0]       axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rlast;
    logic              axi_rvalid;
    logic              axi_rready;

    modport master (
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion, axi_rready,
        input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
    );

    modport slave (
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion, axi_rready,
        output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
    );
endinterface

// File: rtl/axi_imem_rd_slave.sv
// AXI4 read-only responder over a 64-bit synchronous-read instruction memory, one burst at a time.
// Define AXI_IMEM_DECERR_EN to answer out-of-range beats with DECERR instead of wrapping modulo Depth.
module axi_imem_rd_slave #(
    parameter int AxiIdW   = 4,
    parameter int Depth    = 4096,
    parameter     InitFile = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_imem_rd_slave_if.slave  bus
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [AxiIdW-1:0] id_q;
    logic [31:0]       addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              err_q;
    logic [7:0]        cnt_q;

    logic [63:0]       mem [Depth];
    logic [63:0]       mem_q;
    logic [AW-1:0]     rd_idx;

    logic [31:0]       step, bound, next_addr;
    logic              ar_hs, r_hs, last, err_in;
    logic [1:0]        resp;

    assign ar_hs = bus.axi_arvalid && (state_q == IDLE);
    assign r_hs  = (state_q == BURST) && bus.axi_rready;
    assign last  = (cnt_q == len_q);

    // WRAP lengths other than 2/4/8/16 beats, reserved burst type or beats wider than the bus
    assign err_in = (bus.axi_arsize > 3'd3) || (bus.axi_arburst == 2'd3) ||
                    ((bus.axi_arburst == 2'd2) && !(bus.axi_arlen == 8'd1 || bus.axi_arlen == 8'd3 ||
                                                    bus.axi_arlen == 8'd7 || bus.axi_arlen == 8'd15));

    always_comb begin
        step      = 32'd1 << size_q;
        bound     = ({24'd0, len_q} + 32'd1) << size_q;
        next_addr = addr_q;
        case (burst_q)
            2'd1:    next_addr = addr_q + step;
            2'd2:    next_addr = (addr_q & ~(bound - 32'd1)) | ((addr_q + step) & (bound - 32'd1));
            default: next_addr = addr_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = BURST;
            BURST:   if (r_hs && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ar_hs) begin
                id_q    <= bus.axi_arid;
                addr_q  <= bus.axi_araddr;
                len_q   <= bus.axi_arlen;
                size_q  <= bus.axi_arsize;
                burst_q <= bus.axi_arburst;
                err_q   <= err_in;
                cnt_q   <= '0;
            end else if (r_hs) begin
                addr_q <= next_addr;
                cnt_q  <= cnt_q + 8'd1;
            end
        end
    end

    // Stalled beats re-read the current word so the registered output never changes under them
    always_comb begin
        rd_idx = addr_q[AW+2:3];
        if (ar_hs)     rd_idx = bus.axi_araddr[AW+2:3];
        else if (r_hs) rd_idx = next_addr[AW+2:3];
    end

    always_ff @(posedge clk) mem_q <= mem[rd_idx];

`ifdef AXI_IMEM_DECERR_EN
    logic oor;
    assign oor = (addr_q[31:3] >> AW) != '0;
    always_comb begin
        resp = 2'd0;
        if (err_q)    resp = 2'd2;
        else if (oor) resp = 2'd3;
    end
`else
    assign resp = err_q ? 2'd2 : 2'd0;
`endif

    assign bus.axi_arready = (state_q == IDLE);
    assign bus.axi_rvalid  = (state_q == BURST);
    assign bus.axi_rlast   = (state_q == BURST) && last;
    assign bus.axi_rid     = id_q;
    assign bus.axi_rresp   = (state_q == BURST) ? resp : 2'd0;
    assign bus.axi_rdata   = ((state_q == BURST) && (resp == 2'd0)) ? mem_q : 64'd0;

    logic unused_sideband;
    assign unused_sideband = ^{bus.axi_arlock, bus.axi_arcache, bus.axi_arprot,
                               bus.axi_arqos, bus.axi_arregion};
endmodule
